mrv1_rf_wb_arb: RTL and testbench
=================================

Name: mrv1_rf_wb_arb

Overview:
- Writeback arbiter and sequencer for the multithreaded core's single register-file write port.
- Accepts register writes from NUM_SRC_P writeback sources (e.g. ALU, LSU, MUL/DIV) through valid/ready handshakes.
- Picks one source per cycle round-robin, registers the winner in a one-entry output stage and drives the RF write port (tid, addr, data, enable).
- Honours an RF-side stall and counts arbitration conflicts for performance monitoring.

Parameters:
- DATA_WIDTH_P, 32: register data width.
- NUM_THREADS_P, 8: hardware threads.
- rf_addr_width_p, 5: architectural register index width.
- NUM_SRC_P, 2: number of writeback sources (>=2).
- tid_width_lp, $clog2(NUM_THREADS_P): thread id width.
- src_width_lp, $clog2(NUM_SRC_P): source index width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous reset, active-high.
- src_v_i  in  NUM_SRC_P  per-source write request valid.
- src_ready_o  out  NUM_SRC_P  per-source grant/accept; transfer when v&ready.
- src_tid_i  in  NUM_SRC_P x tid_width_lp  per-source thread id.
- src_addr_i  in  NUM_SRC_P x rf_addr_width_p  per-source destination register.
- src_data_i  in  NUM_SRC_P x DATA_WIDTH_P  per-source write data.
- rf_stall_i  in  1  RF port unavailable this cycle; output stage must hold.
- rd_w_en_o  out  1  RF write enable.
- rd_tid_o  out  tid_width_lp  RF write thread id.
- rd_addr_o  out  rf_addr_width_p  RF write register index.
- rd_data_o  out  DATA_WIDTH_P  RF write data.
- rd_src_o  out  src_width_lp  source index of the entry currently in the output stage.
- conflict_cnt_o  out  32  saturating count of conflict cycles.

Behaviour:
- State:
  - out_valid_q: output stage occupied.
  - Output payload registers: tid, addr, data, src.
  - rr_q: round-robin pointer, src_width_lp bits.
  - conflict counter.
- Reset (async, rst_i=1):
  - out_valid_q=0, rr_q=0, conflict_cnt_o=0.
  - Payload registers cleared to 0.
  - rd_w_en_o=0 and src_ready_o=0 while rst_i is high.
  - Reset mid-operation discards a pending output entry; no RF write occurs for it.
- Drain:
  - rd_w_en_o = out_valid_q & ~rf_stall_i.
  - The entry retires in any cycle where rd_w_en_o=1.
  - While rf_stall_i=1 the payload holds stable.
- Accept condition: can_accept = ~out_valid_q | ~rf_stall_i. The stage is empty, or it drains this cycle.
- Grant (combinational):
  - If can_accept, grant goes to the first valid source scanning from index rr_q upward, wrapping modulo NUM_SRC_P.
  - At most one src_ready_o bit is high.
  - src_ready_o=0 for all sources when can_accept=0.
  - src_ready_o may depend combinationally on src_v_i and rf_stall_i.
- Latency: a source accepted in cycle N appears with rd_w_en_o=1 in cycle N+1 if rf_stall_i=0 in N+1; otherwise it appears in the first non-stalled cycle after.
- Throughput: one write per cycle with no stall (back-to-back accept and drain in the same cycle).
- x0 handling:
  - A granted request with addr==0 is accepted (ready=1) but dropped; out_valid_q is not set by it.
  - If the stage drained in that cycle, out_valid_q becomes 0.
  - rr_q still advances.
- Pointer update:
  - On any grant to source i, rr_q <= (i+1) mod NUM_SRC_P.
  - No grant: rr_q holds.
- Stage update:
  - On grant with addr!=0: load payload, out_valid_q<=1.
  - Else if drained: out_valid_q<=0.
- Conflict counter:
  - Increments by 1 in each cycle where can_accept=1 and two or more src_v_i bits are high.
  - Saturates at 0xFFFFFFFF.
- Sources must hold valid and payload stable until accepted. The arbiter does not check this.
- Writes to the same tid/addr from different sources are serialized in grant order. Ordering between sources is not guaranteed beyond round-robin.

Test Plan:
1. Reset with src_v_i=2'b11 asserted -> src_ready_o=0, rd_w_en_o=0. After release, cycle 1: ready=2'b01. Cycle 2: rd_w_en_o=1, rd_src_o=0.
2. Both sources valid continuously for 4 cycles, no stall: tid 3 and 5; data 0xA5A5_0001 and 0x5A5A_0002; addrs 7 and 9 -> grants alternate 0,1,0,1. RF writes appear one cycle later in the same order. conflict_cnt_o=4.
3. Source 0 accepted (tid 2, addr 4, data 0x1234), then rf_stall_i=1 for 3 cycles -> rd_w_en_o=0 and payload stable for those 3 cycles. src_ready_o=0 throughout. Write occurs on the first unstalled cycle.
4. Source 1 request with addr=0, data 0xDEAD -> accepted in 1 cycle, no rd_w_en_o pulse. rr_q wraps to 0, so the next simultaneous request grants source 0.
5. Accept entry (tid 1, addr 6), then assert rst_i mid-stall -> rd_w_en_o stays 0. After reset no write for that entry; counters are 0.
6. Preload the conflict counter near saturation (force 0xFFFF_FFFE), then 3 conflict cycles -> conflict_cnt_o=0xFFFF_FFFF and holds.

Source files
------------

// File: rtl/mrv1_rf_wb_arb.sv
`default_nettype none
// ============================================================================
// Module   : mrv1_rf_wb_arb
// Brief    : Round-robin writeback arbiter feeding the single RF write port
//            through a one-entry output stage, with conflict counting.
// Revision : 1.0
// ============================================================================
module mrv1_rf_wb_arb #(
    parameter int DATA_WIDTH_P    = 32,
    parameter int NUM_THREADS_P   = 8,
    parameter int rf_addr_width_p = 5,
    parameter int NUM_SRC_P       = 2,
    localparam int tid_width_lp   = $clog2(NUM_THREADS_P),
    localparam int src_width_lp   = $clog2(NUM_SRC_P)
) (
    input  logic                                         clk_i,
    input  logic                                         rst_i,
    input  logic [NUM_SRC_P-1:0]                         src_v_i,
    output logic [NUM_SRC_P-1:0]                         src_ready_o,
    input  logic [NUM_SRC_P-1:0][tid_width_lp-1:0]       src_tid_i,
    input  logic [NUM_SRC_P-1:0][rf_addr_width_p-1:0]    src_addr_i,
    input  logic [NUM_SRC_P-1:0][DATA_WIDTH_P-1:0]       src_data_i,
    input  logic                                         rf_stall_i,
    output logic                                         rd_w_en_o,
    output logic [tid_width_lp-1:0]                      rd_tid_o,
    output logic [rf_addr_width_p-1:0]                   rd_addr_o,
    output logic [DATA_WIDTH_P-1:0]                      rd_data_o,
    output logic [src_width_lp-1:0]                      rd_src_o,
    output logic [31:0]                                  conflict_cnt_o
);

    logic                        r_out_valid;
    logic [tid_width_lp-1:0]     r_tid;
    logic [rf_addr_width_p-1:0]  r_addr;
    logic [DATA_WIDTH_P-1:0]     r_data;
    logic [src_width_lp-1:0]     r_src;
    logic [src_width_lp-1:0]     r_rr;
    logic [31:0]                 r_conflict_cnt;

    logic                        w_can_accept;
    logic                        w_drain;
    logic                        w_found;
    logic [src_width_lp-1:0]     w_gnt_idx;
    logic [src_width_lp-1:0]     w_rr_next;
    logic                        w_grant;
    logic                        w_load;
    logic                        w_conflict;

    // Reset gating keeps the handshake and write enable quiet while rst_i is high.
    assign w_can_accept = ~rst_i & (~r_out_valid | ~rf_stall_i);
    assign w_drain      = ~rst_i & r_out_valid & ~rf_stall_i;

    always_comb begin
        logic [src_width_lp-1:0] cand;
        cand      = '0;
        w_found   = 1'b0;
        w_gnt_idx = '0;
        for (int k = 0; k < NUM_SRC_P; k++) begin
            cand = src_width_lp'((int'(r_rr) + k) % NUM_SRC_P);
            if (!w_found && src_v_i[cand]) begin
                w_found   = 1'b1;
                w_gnt_idx = cand;
            end
        end
    end

    assign w_grant    = w_can_accept & w_found;
    assign w_rr_next  = src_width_lp'((int'(w_gnt_idx) + 1) % NUM_SRC_P);
    // Writes to x0 are consumed from the source but never reach the RF.
    assign w_load     = w_grant & (src_addr_i[w_gnt_idx] != '0);
    assign w_conflict = w_can_accept & ($countones(src_v_i) >= 2);

    always_comb begin
        src_ready_o = '0;
        if (w_grant) begin
            src_ready_o[w_gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_out_valid    <= 1'b0;
            r_tid          <= '0;
            r_addr         <= '0;
            r_data         <= '0;
            r_src          <= '0;
            r_rr           <= '0;
            r_conflict_cnt <= '0;
        end else begin
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_tid       <= src_tid_i[w_gnt_idx];
                r_addr      <= src_addr_i[w_gnt_idx];
                r_data      <= src_data_i[w_gnt_idx];
                r_src       <= w_gnt_idx;
            end else if (w_drain) begin
                r_out_valid <= 1'b0;
            end
            if (w_grant) begin
                r_rr <= w_rr_next;
            end
            if (w_conflict && (r_conflict_cnt != 32'hFFFF_FFFF)) begin
                r_conflict_cnt <= r_conflict_cnt + 32'd1;
            end
        end
    end

    assign rd_w_en_o      = w_drain;
    assign rd_tid_o       = r_tid;
    assign rd_addr_o      = r_addr;
    assign rd_data_o      = r_data;
    assign rd_src_o       = r_src;
    assign conflict_cnt_o = r_conflict_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mrv1_rf_wb_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_mrv1_rf_wb_arb
// Brief    : Directed scoreboard bench for the RF writeback arbiter.
// Revision : 1.0
// ============================================================================
module tb_mrv1_rf_wb_arb;

    typedef struct packed {
        logic [2:0]  tid;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        src;
    } wr_t;

    logic                  clk;
    logic                  rst;
    logic [1:0]            src_v;
    logic [1:0]            src_ready;
    logic [1:0][2:0]       src_tid;
    logic [1:0][4:0]       src_addr;
    logic [1:0][31:0]      src_data;
    logic                  rf_stall;
    logic                  rd_w_en;
    logic [2:0]            rd_tid;
    logic [4:0]            rd_addr;
    logic [31:0]           rd_data;
    logic                  rd_src;
    logic [31:0]           conflict_cnt;

    int  total = 0;
    int  bad   = 0;
    wr_t sb[$];
    logic exp_occ = 1'b0;

    mrv1_rf_wb_arb #(
        .DATA_WIDTH_P    (32),
        .NUM_THREADS_P   (8),
        .rf_addr_width_p (5),
        .NUM_SRC_P       (2)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .src_v_i        (src_v),
        .src_ready_o    (src_ready),
        .src_tid_i      (src_tid),
        .src_addr_i     (src_addr),
        .src_data_i     (src_data),
        .rf_stall_i     (rf_stall),
        .rd_w_en_o      (rd_w_en),
        .rd_tid_o       (rd_tid),
        .rd_addr_o      (rd_addr),
        .rd_data_o      (rd_data),
        .rd_src_o       (rd_src),
        .conflict_cnt_o (conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive at the negedge, check 1ns later, then advance to the next negedge.
    task automatic cyc(input logic [1:0] v, input logic stall, input logic [1:0] er, input string tag);
        wr_t e;
        src_v    = v;
        rf_stall = stall;
        #1;
        chk({tag, " ready"}, 64'(src_ready), 64'(er));
        chk({tag, " wen"}, 64'(rd_w_en), 64'(exp_occ & ~stall));
        if (exp_occ && sb.size() > 0) begin
            e = sb[0];
            chk({tag, " tid"},  64'(rd_tid),  64'(e.tid));
            chk({tag, " addr"}, 64'(rd_addr), 64'(e.addr));
            chk({tag, " data"}, 64'(rd_data), 64'(e.data));
            chk({tag, " src"},  64'(rd_src),  64'(e.src));
            if (!stall) begin
                e = sb.pop_front();
                exp_occ = 1'b0;
            end
        end
        for (int i = 0; i < 2; i++) begin
            if (er[i] && src_addr[i] != 5'd0) begin
                sb.push_back('{tid: src_tid[i], addr: src_addr[i], data: src_data[i], src: 1'(i)});
                exp_occ = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst      = 1'b1;
        src_v    = 2'b00;
        rf_stall = 1'b0;
        src_tid  = '{3'd5, 3'd3};
        src_addr = '{5'd9, 5'd7};
        src_data = '{32'h5A5A_0002, 32'hA5A5_0001};

        // Reset held with both sources requesting
        @(negedge clk);
        src_v = 2'b11;
        #1;
        chk("rst ready", 64'(src_ready), 64'd0);
        chk("rst wen",   64'(rd_w_en),   64'd0);
        chk("rst cnt",   64'(conflict_cnt), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Alternating grants under continuous contention
        cyc(2'b11, 1'b0, 2'b01, "rr0");
        cyc(2'b11, 1'b0, 2'b10, "rr1");
        cyc(2'b11, 1'b0, 2'b01, "rr2");
        cyc(2'b11, 1'b0, 2'b10, "rr3");
        cyc(2'b00, 1'b0, 2'b00, "rr_drain");
        chk("rr cnt", 64'(conflict_cnt), 64'd4);

        // Stall holds the stage and blocks all grants
        src_tid[0] = 3'd2; src_addr[0] = 5'd4;  src_data[0] = 32'h0000_1234;
        src_tid[1] = 3'd6; src_addr[1] = 5'd11; src_data[1] = 32'h0000_BEEF;
        cyc(2'b01, 1'b0, 2'b01, "st_acc");
        cyc(2'b10, 1'b1, 2'b00, "st1");
        cyc(2'b10, 1'b1, 2'b00, "st2");
        cyc(2'b10, 1'b1, 2'b00, "st3");
        cyc(2'b10, 1'b0, 2'b10, "st_rel");
        cyc(2'b00, 1'b0, 2'b00, "st_drain");

        // x0 write is consumed without an RF write; pointer wraps to 0
        src_addr[1] = 5'd0; src_data[1] = 32'h0000_DEAD;
        cyc(2'b10, 1'b0, 2'b10, "x0_acc");
        cyc(2'b00, 1'b0, 2'b00, "x0_none");
        src_tid[0] = 3'd3; src_addr[0] = 5'd7; src_data[0] = 32'h0000_0077;
        src_tid[1] = 3'd4; src_addr[1] = 5'd9; src_data[1] = 32'h0000_0099;
        cyc(2'b11, 1'b0, 2'b01, "x0_wrap");
        cyc(2'b00, 1'b0, 2'b00, "x0_drain");
        chk("x0 cnt", 64'(conflict_cnt), 64'd5);

        // Reset during a stall discards the pending entry
        src_tid[0] = 3'd1; src_addr[0] = 5'd6; src_data[0] = 32'h0000_0066;
        cyc(2'b01, 1'b0, 2'b01, "mr_acc");
        cyc(2'b00, 1'b1, 2'b00, "mr_stall");
        rst = 1'b1; src_v = 2'b01; rf_stall = 1'b1;
        #1;
        chk("mr rst wen",   64'(rd_w_en),   64'd0);
        chk("mr rst ready", 64'(src_ready), 64'd0);
        chk("mr rst cnt",   64'(conflict_cnt), 64'd0);
        sb.delete();
        exp_occ = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        cyc(2'b00, 1'b0, 2'b00, "mr_post");
        chk("mr tid",  64'(rd_tid),  64'd0);
        chk("mr addr", 64'(rd_addr), 64'd0);
        chk("mr data", 64'(rd_data), 64'd0);
        chk("mr cnt",  64'(conflict_cnt), 64'd0);

        // Saturation of the conflict counter
        force dut.r_conflict_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.r_conflict_cnt;
        cyc(2'b11, 1'b0, 2'b01, "sat0");
        chk("sat cnt1", 64'(conflict_cnt), 64'hFFFF_FFFF);
        cyc(2'b11, 1'b0, 2'b10, "sat1");
        cyc(2'b11, 1'b0, 2'b01, "sat2");
        cyc(2'b00, 1'b0, 2'b00, "sat_drain");
        chk("sat cnt3", 64'(conflict_cnt), 64'hFFFF_FFFF);
        chk("sb empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
